// File: rtl/xor_and_pipe.sv
// Elastic pipeline computing (data ^ mask) & ctrl with valid/ready on both sides,
// a programmable mask register and a wrapping output-handshake counter.
module xor_and_pipe #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] MASK_RST = WIDTH'('hF0)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mask_we_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic [WIDTH-1:0] mask_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] ctrl_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [15:0]      count_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAST  = STAGES - 1;

    logic [WIDTH-1:0]  mask_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv;
    logic [CNT_W-1:0]  count_q;
    logic              busy_q;

    // A stage may advance unless it and every stage after it are full while
    // downstream stalls; depends only on valid bits and ready_i, never valid_i.
    always_comb begin : ready_chain
        logic all_full;
        adv      = '0;
        all_full = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            all_full        = all_full & v_q[LAST - i];
            adv[LAST - i]   = ready_i | ~all_full;
        end
    end

    always_comb begin : valid_next
        v_d = v_q;
        if (adv[0]) begin
            v_d[0] = valid_i;
        end
        for (int s = 1; s < STAGES; s++) begin
            if (adv[s]) begin
                v_d[s] = v_q[s-1];
            end
        end
    end

    // Mask is applied at acceptance; later stages only shift data forward.
    always_ff @(posedge clk_i or posedge rst_i) begin : stage_regs
        if (rst_i) begin
            v_q    <= '0;
            busy_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            v_q    <= v_d;
            busy_q <= |v_d;
            if (adv[0] && valid_i) begin
                data_q[0] <= (data_i ^ mask_q) & ctrl_i;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (adv[s] && v_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : mask_reg
        if (rst_i) begin
            mask_q <= MASK_RST;
        end else if (mask_we_i) begin
            mask_q <= mask_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : count_reg
        if (rst_i) begin
            count_q <= '0;
        end else if (v_q[LAST] && ready_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign ready_o  = adv[0];
    assign result_o = data_q[LAST];
    assign valid_o  = v_q[LAST];
    assign mask_o   = mask_q;
    assign count_o  = count_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_xor_and_pipe.sv
// Directed bench for xor_and_pipe: default 8-bit/2-stage instance plus a
// 16-bit/1-stage instance with a non-default reset mask.
module tb_xor_and_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, 2-stage instance
    logic        rst, mask_we, valid_in, ready_in, ready_out, valid_out, busy;
    logic [7:0]  mask_in, mask_out, data, ctrl, result;
    logic [15:0] count;

    // 16-bit, 1-stage instance
    logic        rst16, mask_we16, valid_in16, ready_in16, ready_out16, valid_out16, busy16;
    logic [15:0] mask_in16, mask_out16, data16, ctrl16, result16;
    logic [15:0] count16;

    xor_and_pipe dut8 (
        .clk_i(clk), .rst_i(rst), .mask_we_i(mask_we), .mask_i(mask_in), .mask_o(mask_out),
        .data_i(data), .ctrl_i(ctrl), .valid_i(valid_in), .ready_o(ready_out),
        .result_o(result), .valid_o(valid_out), .ready_i(ready_in),
        .count_o(count), .busy_o(busy)
    );

    xor_and_pipe #(.WIDTH(16), .STAGES(1), .MASK_RST(16'h00FF)) dut16 (
        .clk_i(clk), .rst_i(rst16), .mask_we_i(mask_we16), .mask_i(mask_in16), .mask_o(mask_out16),
        .data_i(data16), .ctrl_i(ctrl16), .valid_i(valid_in16), .ready_o(ready_out16),
        .result_o(result16), .valid_o(valid_out16), .ready_i(ready_in16),
        .count_o(count16), .busy_o(busy16)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [7:0] out_q[$];
    int         cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every output handshake of the 8-bit instance
    always @(posedge clk) begin
        if (mon_en && valid_out && ready_in) begin
            out_q.push_back(result);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset8();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        int accepted;
        int bound;

        rst = 1'b1; mask_we = 1'b0; mask_in = '0; data = '0; ctrl = '0;
        valid_in = 1'b0; ready_in = 1'b0;
        rst16 = 1'b1; mask_we16 = 1'b0; mask_in16 = '0; data16 = '0; ctrl16 = '0;
        valid_in16 = 1'b0; ready_in16 = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_mask", 32'(mask_out), 32'hF0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(ready_out), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);

        // First transfer right after reset release; latency 2
        rst = 1'b0;
        data = 8'h3C; ctrl = 8'hFF; valid_in = 1'b1; ready_in = 1'b1;
        #1;
        check("first_ready", 32'(ready_out), 32'h1);
        tick();
        valid_in = 1'b0;
        check("lat_n1_valid", 32'(valid_out), 32'h0);
        check("lat_n1_busy", 32'(busy), 32'h1);
        tick();
        check("lat_n2_valid", 32'(valid_out), 32'h1);
        check("lat_n2_result", 32'(result), 32'hCC);
        tick();
        check("first_count", 32'(count), 32'h1);
        check("first_drained", 32'(valid_out), 32'h0);

        // Streaming: 20 back-to-back transfers
        reset8();
        mon_en = 1'b1;
        ready_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data = 8'(k); ctrl = 8'h0F; valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        repeat (3) tick();
        check("stream_n", 32'(out_q.size()), 32'd20);
        for (int k = 0; k < 20 && k < out_q.size(); k++) begin
            check($sformatf("stream_val%0d", k), 32'(out_q[k]), 32'((8'(k) ^ 8'hF0) & 8'h0F));
            check($sformatf("stream_gap%0d", k), 32'(cyc_q[k] - cyc_q[0]), 32'(k));
        end
        check("stream_count", 32'(count), 32'd20);

        // Backpressure: capacity 2, then drain in order
        reset8();
        ready_in = 1'b0;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            data = 8'(accepted); ctrl = 8'hFF; valid_in = 1'b1;
            #1;
            if (ready_out) accepted++;
            tick();
        end
        check("bp_accepted", 32'(accepted), 32'd2);
        #1;
        check("bp_ready_low", 32'(ready_out), 32'h0);
        check("bp_hold_valid", 32'(valid_out), 32'h1);
        check("bp_hold_result", 32'(result), 32'hF0);
        tick();
        check("bp_hold_result2", 32'(result), 32'hF0);
        ready_in = 1'b1;
        #1;
        check("bp_full_pass", 32'(ready_out), 32'h1);
        bound = 0;
        while (accepted < 5 && bound < 20) begin
            data = 8'(accepted); valid_in = 1'b1;
            #1;
            if (ready_out) accepted++;
            tick();
            bound++;
        end
        valid_in = 1'b0;
        repeat (4) tick();
        check("bp_n", 32'(out_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < out_q.size(); k++)
            check($sformatf("bp_val%0d", k), 32'(out_q[k]), 32'(8'(k) ^ 8'hF0));
        check("bp_count", 32'(count), 32'd5);

        // Mask write coincident with acceptance uses the old mask
        reset8();
        ready_in = 1'b1;
        mask_we = 1'b1; mask_in = 8'h00; data = 8'h55; ctrl = 8'hFF; valid_in = 1'b1;
        tick();
        mask_we = 1'b0;
        check("mask_updated", 32'(mask_out), 32'h00);
        data = 8'h55;
        tick();
        valid_in = 1'b0;
        repeat (3) tick();
        check("mask_n", 32'(out_q.size()), 32'd2);
        if (out_q.size() >= 2) begin
            check("mask_old", 32'(out_q[0]), 32'hA5);
            check("mask_new", 32'(out_q[1]), 32'h55);
        end

        // Asynchronous reset with both stages valid
        reset8();
        ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data = 8'(i); ctrl = 8'hFF; valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0; ready_in = 1'b0;
        check("mid_pre_count", 32'(count), 32'd2);
        check("mid_pre_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_valid", 32'(valid_out), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_count", 32'(count), 32'h0);
        check("mid_ready", 32'(ready_out), 32'h1);
        #1 rst = 1'b0;
        ready_in = 1'b1;
        repeat (3) tick();
        check("mid_n", 32'(out_q.size()), 32'd2);
        if (out_q.size() >= 2) begin
            check("mid_val0", 32'(out_q[0]), 32'hF1);
            check("mid_val1", 32'(out_q[1]), 32'hF2);
        end
        mon_en = 1'b0;

        // 16-bit, single-stage instance
        rst16 = 1'b0;
        check("w16_rst_mask", 32'(mask_out16), 32'h00FF);
        check("w16_rst_valid", 32'(valid_out16), 32'h0);
        check("w16_rst_result", 32'(result16), 32'h0);
        data16 = 16'h1234; ctrl16 = 16'hFFFF; valid_in16 = 1'b1; ready_in16 = 1'b1;
        #1;
        check("w16_ready", 32'(ready_out16), 32'h1);
        tick();
        valid_in16 = 1'b0;
        check("w16_lat_valid", 32'(valid_out16), 32'h1);
        check("w16_lat_result", 32'(result16), 32'h12CB);
        tick();
        check("w16_count", 32'(count16), 32'h1);
        check("w16_drained", 32'(valid_out16), 32'h0);
        ready_in16 = 1'b0;
        data16 = 16'hABCD; ctrl16 = 16'h0F0F; valid_in16 = 1'b1;
        tick();
        check("w16_bp_ready", 32'(ready_out16), 32'h0);
        check("w16_bp_result", 32'(result16), 32'h0B02);
        tick();
        check("w16_bp_hold", 32'(result16), 32'h0B02);
        #2 rst16 = 1'b1;
        #1;
        check("w16_mid_valid", 32'(valid_out16), 32'h0);
        check("w16_mid_busy", 32'(busy16), 32'h0);
        check("w16_mid_count", 32'(count16), 32'h0);
        #1 rst16 = 1'b0;
        valid_in16 = 1'b0; ready_in16 = 1'b1;
        tick();
        check("w16_no_ghost", 32'(valid_out16), 32'h0);

        // Counter wrap after 65537 handshakes
        reset8();
        ready_in = 1'b1; data = 8'h00; ctrl = 8'h00; valid_in = 1'b1;
        repeat (65537) tick();
        valid_in = 1'b0;
        repeat (3) tick();
        check("wrap_count", 32'(count), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
